hazard_pipe: RTL and testbench

Instruction-tracking pipeline and hazard stall unit for the 5-stage core. Latches the fetched instruction word through the D/E/M/W stages and publishes `instrD`, `instrE`, `instrM` and `instrW` to the forwarding control and datapath decoders. It detects the hazards that forwarding cannot cover (load-use, and branch/jr operand-not-ready) and inserts bubbles for them. It also tracks multiply/divide unit occupancy and stalls HI/LO accesses until the result is ready.

---
 rtl/hazard_pipe_if.sv | 25 ++
 rtl/hazard_pipe.sv | 191 +++++++++++++++++++
 tb/tb_hazard_pipe.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_pipe_if.sv
// hazard_pipe_if: instruction stream and stall/status bundle between the
// fetch stage (master) and the hazard/tracking pipeline (slave).
interface hazard_pipe_if;
    logic [31:0] instrF;
    logic [31:0] instrD;
    logic [31:0] instrE;
    logic [31:0] instrM;
    logic [31:0] instrW;
    logic        StallF;
    logic        StallD;
    logic        FlushE;
    logic        md_busy;

    modport master (
        output instrF,
        input  instrD, instrE, instrM, instrW,
        input  StallF, StallD, FlushE, md_busy
    );

    modport slave (
        input  instrF,
        output instrD, instrE, instrM, instrW,
        output StallF, StallD, FlushE, md_busy
    );
endinterface

// File: rtl/hazard_pipe.sv
// hazard_pipe: carries the fetched instruction word through D/E/M/W and
// inserts bubbles for hazards forwarding cannot hide (load-use, branch/jr
// operand not ready). With MDU_STALL_EN defined it also tracks the
// multiply/divide unit and holds HI/LO accesses until the result is ready;
// without it the MDU is treated as single-cycle and md_busy is tied low.
module hazard_pipe #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic         clk,
    input  logic         rst,
    hazard_pipe_if.slave bus
);
    localparam logic [4:0] REG_ZERO   = 5'd0;
    localparam logic [5:0] OP_SPECIAL = 6'h00;

    function automatic logic is_cal_r(input logic [31:0] w);
        logic hit;
        hit = 1'b0;
        if (w[31:26] == OP_SPECIAL) begin
            case (w[5:0])
                6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                6'h2A, 6'h2B: hit = 1'b1;
                default:      hit = 1'b0;
            endcase
        end else begin
            hit = 1'b0;
        end
        return hit;
    endfunction

    function automatic logic is_cal_i(input logic [31:0] w);
        return (w[31:29] == 3'b001);
    endfunction

    function automatic logic is_ld(input logic [31:0] w);
        logic hit;
        case (w[31:26])
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: hit = 1'b1;
            default:                           hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic logic is_st(input logic [31:0] w);
        logic hit;
        case (w[31:26])
            6'h28, 6'h29, 6'h2B: hit = 1'b1;
            default:             hit = 1'b0;
        endcase
        return hit;
    endfunction

    function automatic logic is_btype(input logic [31:0] w);
        return (w[31:26] == 6'h04) || (w[31:26] == 6'h05);
    endfunction

    function automatic logic is_jr(input logic [31:0] w);
        return (w[31:26] == OP_SPECIAL) && (w[5:0] == 6'h08);
    endfunction

    // funct 0x18..0x1B: mult, multu, div, divu
    function automatic logic is_muldiv(input logic [31:0] w);
        return (w[31:26] == OP_SPECIAL) && (w[5:2] == 4'b0110);
    endfunction

    // funct 0x10..0x13: mfhi, mthi, mflo, mtlo
    function automatic logic is_hilo(input logic [31:0] w);
        return (w[31:26] == OP_SPECIAL) && (w[5:2] == 4'b0100);
    endfunction

    logic [31:0] instr_d_r, instr_e_r, instr_m_r, instr_w_r;
    logic [4:0]  rs_d_s, rt_d_s, dest_e_s;
    logic        rs_live_s, rt_live_s, branch_d_s;
    logic        load_use_s, br_e_s, br_m_s, mdu_stall_s, stall_s;
    logic        md_busy_s;

    // D-stage hazard detection from the registered stage words only
    always_comb begin
        rs_d_s     = instr_d_r[25:21];
        rt_d_s     = instr_d_r[20:16];
        branch_d_s = is_btype(instr_d_r) | is_jr(instr_d_r);
        rs_live_s  = (is_cal_r(instr_d_r) | is_cal_i(instr_d_r) | is_ld(instr_d_r) |
                      is_st(instr_d_r) | branch_d_s) && (rs_d_s != REG_ZERO);
        rt_live_s  = (is_cal_r(instr_d_r) | is_st(instr_d_r) | is_btype(instr_d_r)) &&
                     (rt_d_s != REG_ZERO);
        if (is_cal_r(instr_e_r)) begin
            dest_e_s = instr_e_r[15:11];
        end else if (is_cal_i(instr_e_r)) begin
            dest_e_s = instr_e_r[20:16];
        end else begin
            dest_e_s = REG_ZERO;
        end
        load_use_s = is_ld(instr_e_r) &&
                     ((rs_live_s && (rs_d_s == instr_e_r[20:16])) ||
                      (rt_live_s && (rt_d_s == instr_e_r[20:16])));
        br_e_s     = branch_d_s &&
                     ((rs_live_s && (rs_d_s == dest_e_s)) ||
                      (rt_live_s && (rt_d_s == dest_e_s)));
        br_m_s     = branch_d_s && is_ld(instr_m_r) &&
                     ((rs_live_s && (rs_d_s == instr_m_r[20:16])) ||
                      (rt_live_s && (rt_d_s == instr_m_r[20:16])));
        stall_s    = load_use_s | br_e_s | br_m_s | mdu_stall_s;
    end

    // Stage registers: D holds and E takes a nop bubble while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_d_r <= 32'h0000_0000;
            instr_e_r <= 32'h0000_0000;
            instr_m_r <= 32'h0000_0000;
            instr_w_r <= 32'h0000_0000;
        end else begin
            instr_d_r <= stall_s ? instr_d_r : bus.instrF;
            instr_e_r <= stall_s ? 32'h0000_0000 : instr_d_r;
            instr_m_r <= instr_e_r;
            instr_w_r <= instr_m_r;
        end
    end

`ifdef MDU_STALL_EN
    localparam int              CNT_W     = $clog2(DIV_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(1'b0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_t;

    mdu_state_t       state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s, load_s;
    logic             md_busy_r;

    // MDU occupancy state, counter and registered busy flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= MDU_IDLE;
            cnt_r     <= CNT_ZERO;
            md_busy_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            md_busy_r <= (cnt_s != CNT_ZERO);
        end
    end

    // Next counter value: any mult/div leaving E (re)loads, otherwise count down
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        load_s  = instr_e_r[1] ? DIV_LOAD : MULT_LOAD;
        case (state_r)
            MDU_IDLE, MDU_BUSY: begin
                if (is_muldiv(instr_e_r)) begin
                    cnt_s   = load_s;
                    state_s = (load_s != CNT_ZERO) ? MDU_BUSY : MDU_IDLE;
                end else if (state_r == MDU_BUSY) begin
                    cnt_s   = cnt_r - CNT_ONE;
                    state_s = (cnt_s != CNT_ZERO) ? MDU_BUSY : MDU_IDLE;
                end else begin
                    cnt_s   = CNT_ZERO;
                    state_s = MDU_IDLE;
                end
            end
            default: begin
                cnt_s   = CNT_ZERO;
                state_s = MDU_IDLE;
            end
        endcase
    end

    assign md_busy_s   = md_busy_r;
    assign mdu_stall_s = (is_muldiv(instr_d_r) | is_hilo(instr_d_r)) &
                         (md_busy_r | is_muldiv(instr_e_r));
`else
    assign md_busy_s   = 1'b0;
    assign mdu_stall_s = 1'b0;
`endif

    assign bus.instrD  = instr_d_r;
    assign bus.instrE  = instr_e_r;
    assign bus.instrM  = instr_m_r;
    assign bus.instrW  = instr_w_r;
    assign bus.StallF  = stall_s;
    assign bus.StallD  = stall_s;
    assign bus.FlushE  = stall_s;
    assign bus.md_busy = md_busy_s;
endmodule

// File: tb/tb_hazard_pipe.sv
// tb_hazard_pipe: table of two-instruction hazard cases with hand-derived
// stall counts, hand-written multi-cycle sequences, and a random stream
// checked cycle by cycle against a behavioural pipeline model.
module tb_hazard_pipe;
    localparam int MULT_C = 5;
    localparam int DIV_C  = 10;
`ifdef MDU_STALL_EN
    localparam bit MDU_EN = 1'b1;
`else
    localparam bit MDU_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hazard_pipe_if bus();
    hazard_pipe #(.MULT_CYCLES(MULT_C), .DIV_CYCLES(DIV_C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef enum {K_OTHER, K_CALR, K_CALI, K_LD, K_ST, K_BR, K_JR, K_MD, K_HL} kind_t;

    // behavioural model: stage words D,E,M,W and remaining MDU busy cycles
    logic [31:0] pipe [4];
    int          busy_left;
    logic [31:0] prog [$];
    int          pc;
    // DUT values sampled in the last tick
    logic [31:0] s_e, s_w, s_f;
    logic        s_st, s_busy;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic kind_t kind_of(input logic [31:0] w);
        logic [5:0] op, fn;
        op = w[31:26];
        fn = w[5:0];
        if (op == 6'h00) begin
            if (fn inside {[6'h20:6'h27], 6'h2A, 6'h2B}) return K_CALR;
            if (fn == 6'h08) return K_JR;
            if (fn inside {[6'h18:6'h1B]}) return K_MD;
            if (fn inside {[6'h10:6'h13]}) return K_HL;
            return K_OTHER;
        end
        if (op inside {[6'h08:6'h0F]}) return K_CALI;
        if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) return K_LD;
        if (op inside {6'h28, 6'h29, 6'h2B}) return K_ST;
        if (op inside {6'h04, 6'h05}) return K_BR;
        return K_OTHER;
    endfunction

    function automatic bit model_stall();
        kind_t      kd, ke, km;
        logic [4:0] src [2];
        bit         used [2];
        logic [4:0] dst_e;
        bit         br, st;
        kd = kind_of(pipe[0]);
        ke = kind_of(pipe[1]);
        km = kind_of(pipe[2]);
        src[0]  = pipe[0][25:21];
        src[1]  = pipe[0][20:16];
        used[0] = kd inside {K_CALR, K_CALI, K_LD, K_ST, K_BR, K_JR};
        used[1] = kd inside {K_CALR, K_ST, K_BR};
        br      = kd inside {K_BR, K_JR};
        dst_e   = (ke == K_CALR) ? pipe[1][15:11] : (ke == K_CALI) ? pipe[1][20:16] : 5'd0;
        st = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (used[i] && src[i] != 5'd0) begin
                if (ke == K_LD && src[i] == pipe[1][20:16]) st = 1'b1;
                if (br && src[i] == dst_e) st = 1'b1;
                if (br && km == K_LD && src[i] == pipe[2][20:16]) st = 1'b1;
            end
        end
        if (MDU_EN && (kd == K_MD || kd == K_HL) && (busy_left > 0 || ke == K_MD)) st = 1'b1;
        return st;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // one clock cycle: drive fetch word, compare DUT to model, advance both
    task automatic tick();
        logic [31:0] f;
        bit          st;
        f = (pc < prog.size()) ? prog[pc] : 32'h0;
        bus.instrF = f;
        st = model_stall();
        #1;
        s_e = bus.instrE; s_w = bus.instrW; s_f = f;
        s_st = bus.StallF; s_busy = bus.md_busy;
        check("instrD", bus.instrD, pipe[0]);
        check("instrE", bus.instrE, pipe[1]);
        check("instrM", bus.instrM, pipe[2]);
        check("instrW", bus.instrW, pipe[3]);
        check("StallF", 32'(bus.StallF), 32'(st));
        check("StallD", 32'(bus.StallD), 32'(st));
        check("FlushE", 32'(bus.FlushE), 32'(st));
        check("md_busy", 32'(bus.md_busy), 32'(busy_left > 0));
        @(posedge clk);
        if (MDU_EN) begin
            if (kind_of(pipe[1]) == K_MD)
                busy_left = (pipe[1][5:0] inside {6'h1A, 6'h1B}) ? DIV_C : MULT_C;
            else if (busy_left > 0)
                busy_left--;
        end
        pipe[3] = pipe[2];
        pipe[2] = pipe[1];
        pipe[1] = st ? 32'h0 : pipe[0];
        if (!st) begin
            pipe[0] = f;
            pc++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.instrF = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) pipe[i] = 32'h0;
        busy_left = 0;
        pc = 0;
        prog.delete();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0] a, b, c;
        int         sel;
        logic [5:0] fns [4];
        fns[0] = 6'h21; fns[1] = 6'h23; fns[2] = 6'h24; fns[3] = 6'h25;
        a = 5'($urandom_range(0, 3));
        b = 5'($urandom_range(0, 3));
        c = 5'($urandom_range(0, 3));
        sel = $urandom_range(0, 19);
        case (sel)
            0, 1, 2: return rtype(a, b, c, fns[$urandom_range(0, 3)]);
            3, 4:    return itype(($urandom_range(0, 1) == 0) ? 6'h09 : 6'h0D, a, b, 16'($urandom));
            5, 6:    return itype(6'h23, a, b, 16'h0004);
            7:       return itype(6'h2B, a, b, 16'h0008);
            8, 9:    return itype(($urandom_range(0, 1) == 0) ? 6'h04 : 6'h05, a, b, 16'h0010);
            10:      return rtype(a, 5'd0, 5'd0, 6'h08);
            11:      return ($urandom_range(0, 2) == 0) ?
                            rtype(a, b, 5'd0, 6'(6'h18 + $urandom_range(0, 3))) : 32'h0;
            12:      return rtype(a, 5'd0, c, 6'(6'h10 + $urandom_range(0, 3)));
            13:      return {6'h03, 26'($urandom)};
            default: return 32'h0;
        endcase
    endfunction

    typedef struct {
        string       name;
        logic [31:0] i0;
        logic [31:0] i1;
        int          stalls_en;
        int          stalls_dis;
    } vec_t;

    localparam int NVEC = 15;
    vec_t tbl [NVEC];

    logic [31:0] e_hist [32];
    logic [31:0] f_hist [32];
    logic [31:0] w_hist [32];
    logic        st_hist [32];
    logic        busy_hist [32];

    initial begin : main
        logic [31:0] lw2, addu, mflo, fst;
        int          cnt, idx;

        tbl[0]  = '{"load_use",      itype(6'h23, 1, 2, 0),  rtype(2, 4, 3, 6'h21), 1, 1};
        tbl[1]  = '{"br_after_ld",   itype(6'h23, 1, 5, 0),  itype(6'h04, 5, 0, 4), 2, 2};
        tbl[2]  = '{"br_after_alu",  itype(6'h09, 0, 5, 1),  itype(6'h04, 5, 0, 4), 1, 1};
        tbl[3]  = '{"reg_zero_ld",   itype(6'h23, 1, 0, 0),  rtype(0, 0, 3, 6'h21), 0, 0};
        tbl[4]  = '{"jr_after_calr", rtype(1, 2, 3, 6'h21),  rtype(3, 0, 0, 6'h08), 1, 1};
        tbl[5]  = '{"mult_mflo",     rtype(1, 2, 0, 6'h18),  rtype(0, 0, 3, 6'h12), 6, 0};
        tbl[6]  = '{"ld_then_sw_rt", itype(6'h23, 1, 2, 0),  itype(6'h2B, 3, 2, 0), 1, 1};
        tbl[7]  = '{"ld_indep",      itype(6'h23, 1, 2, 0),  itype(6'h09, 4, 3, 1), 0, 0};
        tbl[8]  = '{"bne_rt_alu",    rtype(1, 2, 5, 6'h21),  itype(6'h05, 0, 5, 8), 1, 1};
        tbl[9]  = '{"div_mfhi",      rtype(1, 2, 0, 6'h1A),  rtype(0, 0, 4, 6'h10), 11, 0};
        tbl[10] = '{"ld_then_cali",  itype(6'h23, 1, 2, 0),  itype(6'h09, 2, 3, 1), 1, 1};
        tbl[11] = '{"jr_after_ld",   itype(6'h23, 1, 31, 0), rtype(31, 0, 0, 6'h08), 2, 2};
        tbl[12] = '{"beq_rt_ori",    itype(6'h0D, 1, 5, 3),  itype(6'h04, 0, 5, 4), 1, 1};
        tbl[13] = '{"alu_alu_fwd",   rtype(1, 2, 5, 6'h21),  rtype(5, 5, 6, 6'h21), 0, 0};
        tbl[14] = '{"multu_mult",    rtype(1, 2, 0, 6'h19),  rtype(3, 4, 0, 6'h18), 6, 0};

        // asynchronous reset from power-up, checked before any clock edge
        bus.instrF = 32'h0;
        #2 rst = 1'b1;
        #1;
        check("rst_instrD", bus.instrD, 32'h0);
        check("rst_instrE", bus.instrE, 32'h0);
        check("rst_instrM", bus.instrM, 32'h0);
        check("rst_instrW", bus.instrW, 32'h0);
        check("rst_stall", {29'h0, bus.StallF, bus.StallD, bus.FlushE}, 32'h0);
        check("rst_md_busy", 32'(bus.md_busy), 32'h0);
        do_reset();

        // table of two-instruction cases with known stall counts
        for (int i = 0; i < NVEC; i++) begin
            do_reset();
            prog.push_back(tbl[i].i0);
            prog.push_back(tbl[i].i1);
            cnt = 0;
            for (int c = 0; c < 24; c++) begin
                tick();
                if (s_st) cnt++;
            end
            check(tbl[i].name, 32'(cnt), 32'(MDU_EN ? tbl[i].stalls_en : tbl[i].stalls_dis));
        end

        // load-use: one bubble in E, then the addu
        do_reset();
        lw2  = itype(6'h23, 1, 2, 0);
        addu = rtype(2, 4, 3, 6'h21);
        prog.push_back(lw2);
        prog.push_back(addu);
        for (int c = 0; c < 6; c++) begin
            tick();
            e_hist[c] = s_e;
            st_hist[c] = s_st;
        end
        check("lu_no_early_stall", 32'(st_hist[1]), 32'h0);
        check("lu_stall", 32'(st_hist[2]), 32'h1);
        check("lu_bubble_stall", 32'(st_hist[3]), 32'h0);
        check("lu_bubble_E", e_hist[3], 32'h0);
        check("lu_addu_E", e_hist[4], addu);

        // mult then mflo: busy window length and mflo entry point
        do_reset();
        mflo = rtype(0, 0, 3, 6'h12);
        prog.push_back(rtype(1, 2, 0, 6'h18));
        prog.push_back(mflo);
        cnt = 0;
        idx = -1;
        for (int c = 0; c < 20; c++) begin
            tick();
            busy_hist[c] = s_busy;
            if (s_busy) cnt++;
            if (idx < 0 && s_e == mflo) idx = c;
        end
        check("mdu_busy_cycles", 32'(cnt), 32'(MDU_EN ? MULT_C : 0));
        check("mdu_busy_last", 32'(busy_hist[7]), 32'(MDU_EN));
        check("mdu_busy_fallen", 32'(busy_hist[8]), 32'h0);
        check("mflo_enter_E", 32'(idx), 32'(MDU_EN ? 9 : 3));

        // reset asserted mid-divide clears everything before the next edge
        do_reset();
        prog.push_back(rtype(1, 2, 0, 6'h1A));
        prog.push_back(rtype(0, 0, 4, 6'h10));
        prog.push_back(itype(6'h09, 1, 6, 7));
        for (int c = 0; c < 5; c++) tick();
        check("div_busy_before_rst", 32'(bus.md_busy), 32'(MDU_EN));
        #3 rst = 1'b1;
        #1;
        check("mid_rst_instrD", bus.instrD, 32'h0);
        check("mid_rst_instrE", bus.instrE, 32'h0);
        check("mid_rst_instrM", bus.instrM, 32'h0);
        check("mid_rst_instrW", bus.instrW, 32'h0);
        check("mid_rst_stall", {29'h0, bus.StallF, bus.StallD, bus.FlushE}, 32'h0);
        check("mid_rst_md_busy", 32'(bus.md_busy), 32'h0);
        do_reset();

        // independent ALU stream: never stalls, W is F delayed by four cycles
        do_reset();
        for (int k = 0; k < 20; k++) begin
            if (k % 2 == 0)
                prog.push_back(rtype(5'($urandom_range(1, 7)), 5'($urandom_range(1, 7)),
                                     5'(8 + k % 8), 6'h21));
            else
                prog.push_back(itype(6'h09, 5'($urandom_range(1, 7)), 5'(8 + k % 8),
                                     16'($urandom)));
        end
        cnt = 0;
        for (int c = 0; c < 28; c++) begin
            tick();
            f_hist[c] = s_f;
            w_hist[c] = s_w;
            if (s_st) cnt++;
        end
        check("indep_stalls", 32'(cnt), 32'h0);
        for (int c = 4; c < 28; c++) begin
            fst = f_hist[c - 4];
            check("indep_W_delay", w_hist[c], fst);
        end

        // random stream against the model
        do_reset();
        for (int k = 0; k < 400; k++) prog.push_back(rand_instr());
        for (int c = 0; c < 440; c++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
